// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: handshake bundle for the bit-serial adder controller.
//   in_valid / in_ready / a / b       : operand channel (source -> controller)
//   out_valid / out_ready / s / c     : result channel (controller -> consumer)
//   busy                              : controller is mid-operation or holding a result
// The master modport is the environment side (operand source plus result consumer).
// The slave modport is the controller side.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, s, c, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, s, c, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. A single full-adder cell, built
// from two half adders, is reused across WIDTH bits. Bits are processed LSB first,
// one per clock, and a carry flop links consecutive bits.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_ctrl_if.slave
//           (operand handshake, result handshake, s/c result, busy)
// Result {c,s} = a + b, unsigned. out_valid rises exactly WIDTH cycles after
// the operands are accepted.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands; s/c keep the last result
// SHIFT | one sum bit per cycle shifted into s from the MSB end
// HOLD  | out_valid high, s/c frozen until out_ready

module ha (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_q, c_d;

    // Full adder: the first half adder combines the operand bits. The second half
    // adder folds in the carry. Both half adders cannot carry at once, so an OR
    // gives the majority.
    logic ha0_s, ha0_c, ha1_c, sum_bit, carry_next;

    ha u_ha0 (.x_i(a_q[0]), .y_i(b_q[0]),  .s_o(ha0_s),   .c_o(ha0_c));
    ha u_ha1 (.x_i(ha0_s),  .y_i(carry_q), .s_o(sum_bit), .c_o(ha1_c));

    assign carry_next = ha0_c | ha1_c;

    // After WIDTH shifts, the first (LSB) sum bit has travelled down to s[0].
    logic [WIDTH-1:0] s_shift;
    if (WIDTH == 1) begin : g_s_one
        assign s_shift = sum_bit;
    end else begin : g_s_many
        assign s_shift = {sum_bit, s_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                s_d     = s_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    c_d     = carry_next;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == SHIFT) || (state_q == HOLD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.s         = s_q;
    assign bus.c         = c_q;
endmodule
